// File: rtl/hamming_seq.sv
// SECDED Hamming encode sequencer: reads NUM_MSG 11-bit messages, writes 16-bit codewords; 5 cycles per message.
// Owns the memory port while busy; start is honoured only in IDLE, no backpressure from memory.
module hamming_seq #(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30,
    parameter int AW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data,
    output logic          busy,
    output logic          done,
    output logic [3:0]    msg_idx
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_LO = 3'd1;
    localparam logic [2:0] S_RD_HI = 3'd2;
    localparam logic [2:0] S_CAP   = 3'd3;
    localparam logic [2:0] S_WR_LO = 3'd4;
    localparam logic [2:0] S_WR_HI = 3'd5;
    localparam logic [2:0] S_FIN   = 3'd6;

    localparam logic [3:0] LAST_IDX = 4'((NUM_MSG > 0) ? (NUM_MSG - 1) : 0);

    logic [2:0] state_q, state_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] dlo_q, dlo_d;
    logic [2:0] dhi_q, dhi_d;

    logic [11:1]   d;
    logic          p8, p4, p2, p1, p0;
    logic [7:0]    cw_lo, cw_hi;
    logic [AW-1:0] idx_off, src_lo, dst_lo;

    assign d  = {dhi_q, dlo_q};
    assign p8 = ^d[11:5];
    assign p4 = ^{d[11:8], d[4:2]};
    assign p2 = ^{d[11:10], d[7:6], d[4:3], d[1]};
    assign p1 = ^{d[11], d[9], d[7], d[5], d[4], d[2], d[1]};
    assign p0 = ^{d, p8, p4, p2, p1};

    assign cw_hi = {d[11:5], p8};
    assign cw_lo = {d[4:2], p4, d[1], p2, p1, p0};

    // Byte addresses wrap modulo 2^AW by construction of the AW-wide adders.
    assign idx_off = AW'({idx_q, 1'b0});
    assign src_lo  = AW'(SRC_BASE) + idx_off;
    assign dst_lo  = AW'(DST_BASE) + idx_off;

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = done_q;
        idx_d   = idx_q;
        dlo_d   = dlo_q;
        dhi_d   = dhi_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    done_d  = 1'b0;
                    idx_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = (NUM_MSG == 0) ? S_FIN : S_RD_LO;
                end
            end
            S_RD_LO: state_d = S_RD_HI;
            S_RD_HI: begin
                dlo_d   = mem_rd_data;
                state_d = S_CAP;
            end
            S_CAP: begin
                dhi_d   = mem_rd_data[2:0];
                state_d = S_WR_LO;
            end
            S_WR_LO: state_d = S_WR_HI;
            S_WR_HI: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_FIN;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_RD_LO;
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory port is a pure decode of state so reset silences writes without waiting for an edge.
    always_comb begin
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'h00;
        case (state_q)
            S_RD_LO: mem_addr = src_lo;
            S_RD_HI: mem_addr = src_lo + AW'(1);
            S_WR_LO: begin
                mem_addr    = dst_lo;
                mem_wr_en   = 1'b1;
                mem_wr_data = cw_lo;
            end
            S_WR_HI: begin
                mem_addr    = dst_lo + AW'(1);
                mem_wr_en   = 1'b1;
                mem_wr_data = cw_hi;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= 4'd0;
            dlo_q   <= 8'h00;
            dhi_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
            dlo_q   <= dlo_d;
            dhi_q   <= dhi_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign msg_idx = idx_q;

endmodule

// File: tb/tb_hamming_seq.sv
// Bench for hamming_seq: a one-message instance driven from a vector table and a 15-message instance
// driven with random data, both checked against a positional Hamming model.
module tb_hamming_seq;

    localparam int N = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, start1;

    logic [7:0] addr, rd, wdat;
    logic       wen, busy, done;
    logic [3:0] idx;

    logic [7:0] addr1, rd1, wdat1;
    logic       wen1, busy1, done1;
    logic [3:0] idx1;

    hamming_seq #(.NUM_MSG(N), .SRC_BASE(0), .DST_BASE(30), .AW(8)) u_dut (
        .clk(clk), .reset(reset), .start(start), .mem_addr(addr), .mem_rd_data(rd),
        .mem_wr_en(wen), .mem_wr_data(wdat), .busy(busy), .done(done), .msg_idx(idx)
    );

    hamming_seq #(.NUM_MSG(1), .SRC_BASE(0), .DST_BASE(30), .AW(8)) u_one (
        .clk(clk), .reset(reset), .start(start1), .mem_addr(addr1), .mem_rd_data(rd1),
        .mem_wr_en(wen1), .mem_wr_data(wdat1), .busy(busy1), .done(done1), .msg_idx(idx1)
    );

    // Synchronous-read memories; the bench loads them through a side write port.
    logic [7:0] mem  [256];
    logic [7:0] mem1 [256];
    logic       tb_we0, tb_we1;
    logic [7:0] tb_a, tb_d;
    int         wr_cnt = 0, wr_cnt1 = 0, src_hits = 0;

    always @(posedge clk) begin
        rd <= mem[addr];
        if (tb_we0) mem[tb_a] <= tb_d;
        else if (wen) begin
            mem[addr] <= wdat;
            wr_cnt    <= wr_cnt + 1;
            if (addr < 8'd30) src_hits <= src_hits + 1;
        end
    end

    always @(posedge clk) begin
        rd1 <= mem1[addr1];
        if (tb_we1) mem1[tb_a] <= tb_d;
        else if (wen1) begin
            mem1[addr1] <= wdat1;
            wr_cnt1     <= wr_cnt1 + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Codeword bit n is Hamming position n; data fills non-power-of-two positions, bit 0 is overall parity.
    function automatic logic [15:0] ref_cw(input logic [10:0] dat);
        logic [15:0] cw;
        logic        par;
        int          j;
        cw = 16'h0;
        j  = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = dat[j];
                j++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            par = 1'b0;
            for (int pos = 1; pos < 16; pos++)
                if (pos[k]) par = par ^ cw[pos];
            cw[1 << k] = par;
        end
        cw[0] = ^cw;
        return cw;
    endfunction

    task automatic poke(input bit which, input logic [7:0] a, input logic [7:0] dv);
        @(negedge clk);
        tb_a = a;
        tb_d = dv;
        if (which) tb_we1 = 1'b1;
        else tb_we0 = 1'b1;
        @(negedge clk);
        tb_we0 = 1'b0;
        tb_we1 = 1'b0;
    endtask

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] elo;
        logic [7:0] ehi;
    } vec_t;

    task automatic run_one(input string name, input vec_t v);
        int base, done_edge;
        poke(1'b1, 8'd0, v.lo);
        poke(1'b1, 8'd1, v.hi);
        poke(1'b1, 8'd30, 8'hAA);
        poke(1'b1, 8'd31, 8'hAA);
        base      = wr_cnt1;
        done_edge = -1;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (done1 && done_edge < 0) done_edge = k;
        end
        chk({name, "_done_edge"}, done_edge, 6);
        chk({name, "_lo"}, mem1[30], v.elo);
        chk({name, "_hi"}, mem1[31], v.ehi);
        chk({name, "_writes"}, wr_cnt1 - base, 2);
    endtask

    task automatic run_full(input string name, input int disturb_edge, input int reset_edge);
        logic [7:0]  slo [N];
        logic [7:0]  shi [N];
        logic [15:0] cw;
        int base, hits, done_edge, bad, exp_idx;
        for (int i = 0; i < N; i++) begin
            slo[i] = 8'($urandom);
            shi[i] = 8'($urandom);
            poke(1'b0, 8'(2 * i), slo[i]);
            poke(1'b0, 8'(2 * i + 1), shi[i]);
            poke(1'b0, 8'(30 + 2 * i), 8'hAA);
            poke(1'b0, 8'(31 + 2 * i), 8'hAA);
        end
        base      = wr_cnt;
        hits      = src_hits;
        done_edge = -1;
        bad       = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 82; k++) begin
            if (k > 0) @(negedge clk);
            start = (disturb_edge > 0 && k == disturb_edge - 1);
            if (reset_edge > 0 && k == reset_edge - 1) begin
                chk({name, "_idx_before_reset"}, idx, k / 5);
                reset = 1'b0;
                #1;
                chk({name, "_rst_wen"}, wen, 0);
                chk({name, "_rst_busy"}, busy, 0);
                chk({name, "_rst_done"}, done, 0);
                chk({name, "_rst_idx"}, idx, 0);
                base = wr_cnt;
                repeat (4) @(negedge clk);
                reset = 1'b1;
                repeat (6) @(negedge clk);
                chk({name, "_no_writes_after_reset"}, wr_cnt - base, 0);
                chk({name, "_idle_busy"}, busy, 0);
                chk({name, "_idle_done"}, done, 0);
                return;
            end
            exp_idx = (k / 5 > N - 1) ? N - 1 : k / 5;
            if (busy !== (k <= 5 * N)) bad++;
            if (done !== (k >= 5 * N + 1)) bad++;
            if (idx !== 4'(exp_idx)) bad++;
            if (done && done_edge < 0) done_edge = k;
        end
        start = 1'b0;
        chk({name, "_profile_bad_cycles"}, bad, 0);
        chk({name, "_done_edge"}, done_edge, 5 * N + 1);
        chk({name, "_writes"}, wr_cnt - base, 2 * N);
        chk({name, "_src_writes"}, src_hits - hits, 0);
        for (int i = 0; i < N; i++) begin
            cw = ref_cw({shi[i][2:0], slo[i]});
            chk($sformatf("%s_m%0d_lo", name, i), mem[30 + 2 * i], cw[7:0]);
            chk($sformatf("%s_m%0d_hi", name, i), mem[31 + 2 * i], cw[15:8]);
        end
    endtask

    initial begin
        vec_t        tbl [5];
        vec_t        rv;
        logic [15:0] cw;

        tbl[0] = '{lo: 8'h00, hi: 8'h00, elo: 8'h00, ehi: 8'h00};
        tbl[1] = '{lo: 8'hFF, hi: 8'h07, elo: 8'hFF, ehi: 8'hFF};
        tbl[2] = '{lo: 8'h01, hi: 8'h00, elo: 8'h0F, ehi: 8'h00};
        tbl[3] = '{lo: 8'h00, hi: 8'hF8, elo: 8'h00, ehi: 8'h00};
        tbl[4] = '{lo: 8'h00, hi: 8'h04, elo: 8'h17, ehi: 8'h81};

        reset  = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        tb_we0 = 1'b0;
        tb_we1 = 1'b0;
        tb_a   = 8'h00;
        tb_d   = 8'h00;
        #12;
        chk("reset_addr", addr, 0);
        chk("reset_wen", wen, 0);
        chk("reset_wdata", wdat, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_idx", idx, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int t = 0; t < 5; t++)
            run_one($sformatf("vec%0d", t), tbl[t]);

        for (int t = 0; t < 4; t++) begin
            rv.lo  = 8'($urandom);
            rv.hi  = 8'($urandom);
            cw     = ref_cw({rv.hi[2:0], rv.lo});
            rv.elo = cw[7:0];
            rv.ehi = cw[15:8];
            run_one($sformatf("rnd%0d", t), rv);
        end

        run_full("full", 0, 0);
        run_full("busy_start", 20, 0);
        run_full("mid_reset", 0, 33);
        run_full("after_reset", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hamming_seq.md
Name: hamming_seq

Overview:
- Hardware sequencer for program 1 (SECDED Hamming encode).
- After a start pulse, it takes over the data-memory port and walks NUM_MSG 11-bit messages stored as byte pairs at SRC_BASE.
- For each message it computes parity bits p8/p4/p2/p1 and the overall parity bit p0, then writes the 16-bit codewords as byte pairs at DST_BASE.
- It raises done when the last codeword is written. It sits between the top-level start/done handshake and the dm1 memory port.

Parameters:
- NUM_MSG, 15, number of messages to encode.
- SRC_BASE, 0, byte address of the first source message (low byte).
- DST_BASE, 30, byte address of the first output codeword (low byte).
- AW, 8, memory address width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request pulse; sampled only in IDLE.
- mem_addr  out  AW  data-memory byte address.
- mem_rd_data  in  8  read data; valid the cycle after mem_addr is presented (1-cycle synchronous read).
- mem_wr_en  out  1  write strobe; the memory writes mem_wr_data to mem_addr on this edge.
- mem_wr_data  out  8  write data.
- busy  out  1  high from the first cycle after start is accepted until done rises.
- done  out  1  high after the last write; held until the next accepted start.
- msg_idx  out  4  index of the message in progress (0..NUM_MSG-1).

Behaviour:
- Reset (async, reset=0): state=IDLE; mem_addr=0, mem_wr_en=0, mem_wr_data=0, busy=0, done=0, msg_idx=0.
  - Reset may occur mid-sequence: writes stop immediately, and no partial write completes after reset is asserted.
- Message layout for index i:
  - Low byte at SRC_BASE+2i holds d[8:1].
  - High byte at SRC_BASE+2i+1 holds d[11:9] in bits [2:0]. Bits [7:3] are ignored (not required to be zero).
- Parity:
  - p8 = XOR(d11..d5).
  - p4 = XOR(d11..d8, d4, d3, d2).
  - p2 = XOR(d11, d10, d7, d6, d4, d3, d1).
  - p1 = XOR(d11, d9, d7, d5, d4, d2, d1).
  - p0 = XOR(all 11 data bits, p8, p4, p2, p1).
- Output codeword:
  - High byte = {d11..d5, p8}, written to DST_BASE+2i+1.
  - Low byte = {d4, d3, d2, p4, d1, p2, p1, p0}, written to DST_BASE+2i.
- FSM states: IDLE, RD_LO, RD_HI, CAP, WR_LO, WR_HI, FIN.
  - IDLE: if start, clear done and msg_idx, set busy, go to RD_LO (if NUM_MSG=0, go straight to FIN).
  - RD_LO: mem_addr=SRC_BASE+2i.
  - RD_HI: mem_addr=SRC_BASE+2i+1; latch mem_rd_data into the low data register.
  - CAP: latch mem_rd_data[2:0] into the high data register; compute parity combinationally.
  - WR_LO: mem_addr=DST_BASE+2i, mem_wr_en=1, mem_wr_data=low codeword byte.
  - WR_HI: mem_addr=DST_BASE+2i+1, mem_wr_en=1, mem_wr_data=high codeword byte. If i==NUM_MSG-1 go to FIN; else increment msg_idx and go to RD_LO.
  - FIN: clear busy, set done, go to IDLE.
- Timing: 5 cycles per message. If start is sampled at edge 0, the final write occurs at edge 5*NUM_MSG and done is high from edge 5*NUM_MSG+1 (edge 76 for NUM_MSG=15).
- mem_wr_en is high only in WR_LO and WR_HI, so exactly 2*NUM_MSG writes occur per run. No source address is ever written.
- start while busy: ignored, with no restart and no glitch on done.
- start in IDLE with done=1: done drops on the next edge and a new run begins.
- Address arithmetic is modulo 2^AW (wraps silently).

Test Plan:
- Single message (NUM_MSG=1), source bytes lo=0x00, hi=0x00 -> writes DST lo=0x00, hi=0x00; done at edge 6.
- Source d=0x7FF (lo=0xFF, hi=0x07) -> codeword 0xFFFF (lo=0xFF, hi=0xFF).
- Source d=0x001 (lo=0x01, hi=0x00) -> lo=0x0F, hi=0x00. With hi=0xF8, lo=0x00 (garbage upper bits) -> output lo=0x00, hi=0x00.
- 15 random messages at bytes 0..29 -> bytes 30..59 match the parity reference model; exactly 30 writes; done rises at edge 76; busy high edges 1..75.
- Pulse start again at edge 20 while busy -> no effect; same results and done timing as an undisturbed run.
- Assert reset at edge 33 (mid message 6) -> mem_wr_en, busy, done go to 0 immediately; no further writes; msg_idx=0; a new start afterwards completes a full, correct run.
